lcd_rgb_rx: RTL



---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_sync_edge.sv | 30 +++
 rtl/lcd_rgb_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: coordinate widths, receiver FSM states, RGB565 packing.
package lcd_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_WAIT_DE = 2'd1,
    ST_ACTIVE  = 2'd2
  } lcd_state_e;

  function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Clock-enable gated edge detector for one LCD control line; POL is the active level.
module lcd_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce_i,
  input  logic sig_i,
  output logic act_c_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic prev_q;

  assign act_c_o = (sig_i == POL);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (ce_i) begin
      prev_q <= act_c_o;
    end
  end

  // Edges are qualified by ce so they coincide with the sample that shows them.
  assign rise_c_o = ce_i & act_c_o & ~prev_q;
  assign fall_c_o = ce_i & ~act_c_o & prev_q;

endmodule

// File: rtl/lcd_rgb_rx.sv
// Parallel RGB565 LCD receiver: frame sync, pixel coordinates, overflow detection.
// Geometry measurement and line-length checking are built only with LCD_RX_STATS_EN.
module lcd_rgb_rx
  import lcd_pkg::*;
#(
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned MAX_W  = 800,
  parameter int unsigned MAX_H  = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic             lcd_de,
  input  logic             lcd_hsync,
  input  logic             lcd_vsync,
  input  logic [4:0]       lcd_r,
  input  logic [5:0]       lcd_g,
  input  logic [4:0]       lcd_b,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic [X_W-1:0]   frame_width,
  output logic [Y_W-1:0]   frame_height,
  output logic             geom_valid,
  output logic             err_ovf,
  output logic             err_len
);

  localparam logic [X_W-1:0] MAX_X = X_W'(MAX_W);
  localparam logic [Y_W-1:0] MAX_Y = Y_W'(MAX_H);

  logic de_act, de_rise, de_fall;
  logic hs_act, hs_lead, hs_trail;
  logic vs_act, vs_lead, vs_trail;

  lcd_sync_edge #(.POL(1'b1)) u_de (
    .clk(clk), .rst(rst), .ce_i(pix_ce), .sig_i(lcd_de),
    .act_c_o(de_act), .rise_c_o(de_rise), .fall_c_o(de_fall)
  );
  lcd_sync_edge #(.POL(HS_POL)) u_hs (
    .clk(clk), .rst(rst), .ce_i(pix_ce), .sig_i(lcd_hsync),
    .act_c_o(hs_act), .rise_c_o(hs_lead), .fall_c_o(hs_trail)
  );
  lcd_sync_edge #(.POL(VS_POL)) u_vs (
    .clk(clk), .rst(rst), .ce_i(pix_ce), .sig_i(lcd_vsync),
    .act_c_o(vs_act), .rise_c_o(vs_lead), .fall_c_o(vs_trail)
  );

  logic unused_edge;
  assign unused_edge = ^{hs_act, hs_trail, vs_act, vs_trail};

  lcd_state_e     state_q, state_d;
  logic [X_W-1:0] x_q, x_d, x_cur;
  logic [Y_W-1:0] y_q, y_d;
  logic           pix_valid_q, pix_valid_d;
  logic [15:0]    pix_data_q, pix_data_d;
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic           pix_sof_q, pix_sof_d;
  logic           pix_eol_q, pix_eol_d;
  logic           err_ovf_q, err_ovf_d;
  logic           line_end_c;

  // Next state: VSYNC leading edge overrides everything, including a DE-high sample.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    pix_sof_d   = 1'b0;
    pix_eol_d   = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    err_ovf_d   = err_ovf_q;
    line_end_c  = 1'b0;
    x_cur       = de_rise ? '0 : x_q;

    if (vs_lead) begin
      state_d = ST_WAIT_DE;
      x_d     = '0;
      y_d     = '0;
    end else if (pix_ce && (state_q != ST_WAIT_VS)) begin
      if (de_act) begin
        state_d = ST_ACTIVE;
        if ((x_cur < MAX_X) && (y_q < MAX_Y)) begin
          pix_valid_d = 1'b1;
          pix_data_d  = rgb565(lcd_r, lcd_g, lcd_b);
          pix_x_d     = x_cur;
          pix_y_d     = y_q;
          pix_sof_d   = (x_cur == '0) && (y_q == '0);
        end else begin
          err_ovf_d = 1'b1;
        end
        x_d = (x_cur == MAX_X) ? x_cur : x_cur + X_W'(1);
      end else begin
        if (de_fall && (state_q == ST_ACTIVE)) begin
          line_end_c = 1'b1;
          pix_eol_d  = 1'b1;
          y_d        = (y_q == MAX_Y) ? y_q : y_q + Y_W'(1);
        end
        if (hs_lead) begin
          x_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_VS;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_sof_q   <= pix_sof_d;
      pix_eol_q   <= pix_eol_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_sof   = pix_sof_q;
  assign pix_eol   = pix_eol_q;
  assign err_ovf   = err_ovf_q;

`ifdef LCD_RX_STATS_EN
  logic [X_W-1:0] width_q, first_w_q;
  logic [Y_W-1:0] height_q;
  logic           geom_q, len_q;

  // Line 0 sets the reference width; any later line of the frame must match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q   <= '0;
      first_w_q <= '0;
      height_q  <= '0;
      geom_q    <= 1'b0;
      len_q     <= 1'b0;
    end else begin
      if (line_end_c) begin
        width_q <= x_q;
        if (y_q == '0) begin
          first_w_q <= x_q;
        end else if (x_q != first_w_q) begin
          len_q <= 1'b1;
        end
      end
      if (vs_lead && (y_q != '0)) begin
        height_q <= y_q;
        geom_q   <= 1'b1;
      end
    end
  end

  assign frame_width  = width_q;
  assign frame_height = height_q;
  assign geom_valid   = geom_q;
  assign err_len      = len_q;
`else
  logic unused_stats;
  assign unused_stats = line_end_c;

  assign frame_width  = '0;
  assign frame_height = '0;
  assign geom_valid   = 1'b0;
  assign err_len      = 1'b0;
`endif

endmodule
